// File: rtl/arbiter_wrr.sv
// rtl/arbiter_wrr.sv - weighted round-robin arbiter with transaction locking
//
// Grants one of N requesters. A grant is held for a whole multi-beat
// transaction, which ends on a beat with last[i] high. The favoured requester
// (ptr) may complete up to weight[ptr] consecutive transactions before its
// turn passes to the next index. A weight of 0 counts as 1.
//
// Ports:
//   clk       clock
//   rstn      asynchronous active-low reset
//   enable    low forces gnt to 0; internal state is retained
//   req       per-requester request, a beat is offered while high
//   last      per-requester end-of-transaction flag, qualified by the beat
//   ready     downstream accepts the current beat
//   weight    packed weights, weight[i] = weight[i*W +: W]
//   gnt       one-hot grant or 0
//   gnt_id    index of the granted requester, 0 when gnt is 0
//   gnt_valid equals |gnt
//   locked    high while a multi-beat transaction is in progress

module arbiter_wrr #(
  parameter int N   = 4,
  parameter int W   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     last,
  input  logic             ready,
  input  logic [N*W-1:0]   weight,
  output logic [N-1:0]     gnt,
  output logic [IDW-1:0]   gnt_id,
  output logic             gnt_valid,
  output logic             locked
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [0:0]     state;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] ptr;
  logic [W-1:0]   cnt;

  // Rotating priority scan starting at ptr.
  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] idx;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDW'((int'(ptr) + k) % N);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // Once locked, the owner keeps the grant regardless of other requests.
  logic [IDW-1:0] cur_id;
  logic           cur_any;
  logic           gnt_on;
  logic           beat;

  always_comb begin
    cur_id  = (state == S_LOCKED) ? owner : win_id;
    cur_any = (state == S_LOCKED) ? 1'b1 : win_found;
    // rstn gates the grant so nothing leaks out while reset is held.
    gnt_on  = rstn & enable & cur_any;
    beat    = gnt_on & req[cur_id] & ready;
  end

  assign gnt       = gnt_on ? ({{(N-1){1'b0}}, 1'b1} << cur_id) : '0;
  assign gnt_id    = gnt_on ? cur_id : '0;
  assign gnt_valid = |gnt;
  assign locked    = (state == S_LOCKED);

  // Completion bookkeeping for the channel that carries the last beat.
  logic [W-1:0] w_arr [N];
  logic [W:0]   eff_w;
  logic [W:0]   n_done;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_arr[i] = weight[i*W +: W];
    end
    eff_w  = (w_arr[cur_id] == '0) ? (W+1)'(1) : {1'b0, w_arr[cur_id]};
    // A different channel completing starts a fresh turn at one transaction.
    n_done = (cur_id == ptr) ? ({1'b0, cnt} + (W+1)'(1)) : (W+1)'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else if (beat) begin
      if (last[cur_id]) begin
        state <= S_IDLE;
        if (n_done < eff_w) begin
          ptr <= cur_id;
          cnt <= n_done[W-1:0];
        end else begin
          ptr <= (cur_id == IDW'(N-1)) ? '0 : cur_id + IDW'(1);
          cnt <= '0;
        end
      end else if (state == S_IDLE) begin
        state <= S_LOCKED;
        owner <= cur_id;
      end
    end
  end

endmodule

// File: doc/arbiter_wrr.md
Name: arbiter_wrr

Overview:
Parametrised weighted round-robin arbiter with transaction locking. It is the next generation of the single-cycle round-robin arbiter. It grants one of N requesters. A grant is held for a whole multi-beat transaction, delimited by a per-requester last flag. Each requester may complete up to weight[i] consecutive transactions before its turn passes on. It sits in front of shared buses and memory ports in the SoC interconnect.

Parameters:
N, 4, number of requesters (N >= 2)
W, 4, width of each weight field
IDW, $clog2(N), width of gnt_id

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
enable  input  1  when low, forces gnt to 0; internal state is retained
req  input  N  per-requester request; a beat is offered while high
last  input  N  per-requester end-of-transaction flag, qualified by the beat
ready  input  1  downstream accepts the current beat
weight  input  N*W  weight[i] = weight[i*W +: W]; 0 is treated as 1
gnt  output  N  one-hot grant, or 0
gnt_id  output  IDW  index of the granted requester; 0 when gnt == 0
gnt_valid  output  1  equals |gnt
locked  output  1  high while a multi-beat transaction is in progress

Behaviour:
- State registers:
  - state: IDLE or LOCKED.
  - owner: IDW bits.
  - ptr: IDW bits, the favoured requester.
  - cnt: W bits, transactions completed by ptr in its current turn.
- Reset (async): state=IDLE, owner=0, ptr=0, cnt=0. gnt, gnt_id, gnt_valid and locked are all 0 while rstn is low, regardless of req.
- Beat: occurs in a cycle when gnt[i] & req[i] & ready. The beat is the last beat if last[i] is also high.
- IDLE grant (combinational, zero latency): if enable and |req, the winner is the first requester with req high, scanning from ptr upward modulo N. gnt = onehot(winner). Otherwise gnt=0.
- IDLE with no beat (ready low): no state change. The winner may change next cycle if req changes, because there is no lock before the first beat.
- IDLE, first beat without last: state goes to LOCKED and owner is set to the winner on the next edge.
- IDLE, first beat with last (single-beat transaction): stays IDLE and a completion is performed.
- LOCKED grant: gnt = enable ? onehot(owner) : 0, independent of the other requests.
  - If req[owner] drops, the grant is held but no beat occurs.
  - A beat with last[owner] performs a completion and returns the state to IDLE on the next edge.
- Completion by channel c, evaluated at the clock edge of the last beat:
  - eff_w = (weight[c] == 0) ? 1 : weight[c], sampled at that edge.
  - n = (c == ptr) ? cnt+1 : 1, computed in W+1 bits with no wrap.
  - If n < eff_w: ptr=c, cnt=n. Otherwise: ptr=(c+1) mod N, cnt=0.
- Weight changes apply from the next completion onward. A mid-turn weight decrease below cnt+1 ends the turn at the next completion of that channel.
- Back-to-back transactions: a new IDLE arbitration happens in the cycle immediately after the last beat, using the updated ptr. There are no idle bubbles.
- enable low in LOCKED: gnt=0 and locked stays 1. When enable returns high, the grant goes back to the owner.
- Invariants:
  - gnt is one-hot or zero.
  - gnt_id is consistent with gnt.
  - locked == (state == LOCKED).
  - No grant goes to a requester with req low while in IDLE.

Test Plan:
1. N=4, all weights 1, req=1111, last=1111, ready=1, enable=1 -> gnt sequence 0001, 0010, 0100, 1000, 0001, one per cycle.
2. weight[0]=3, others 1, req=1111, single-beat transactions -> gnt 0001 x3, then 0010, 0100, 1000, 0001 x3. cnt at the cycle-3 edge is 0 and ptr is 1.
3. req=0011, ch1 favoured.
   - Stimulus: ch1 runs a 4-beat transaction, last on beat 4, with ready low for 2 cycles between beats 2 and 3.
   - Response: gnt=0010 for 6 cycles and locked=1 from the cycle after beat 1. On the cycle after beat 4, gnt=0001 and locked=0.
4. IDLE, req=0100, ready=0 -> gnt=0100. Then req=0110 with ptr=1 -> gnt=0010 in the same cycle (no lock before the first beat). ptr and cnt are unchanged.
5. In LOCKED with owner=2, drive enable=0 for 3 cycles -> gnt=0, gnt_valid=0, locked=1. Then enable=1 -> gnt=0100 until the last beat.
6. Assert rstn low mid-lock at a non-clock time -> gnt=0 and locked=0 immediately. After release with req=1111, single-beat, the first grant is 0001 (ptr=0).
